// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the iterative 32-bit divider: FSM state encoding,
// iteration count, datapath widths and a small two's-complement helper.
// Configuration macro: DIV_FAST_ZERO_EN adds the ZERO state used by the
// divide-by-zero shortcut.
// -----------------------------------------------------------------------------
package div_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int RESULT_W  = 64;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 6;

`ifdef DIV_FAST_ZERO_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2,
    ZERO   = 2'd3
  } div_state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_t;
`endif

  // Conditionally negate a 32-bit value (two's complement).
  function automatic logic [DATA_W-1:0] neg_if(input logic en,
                                               input logic [DATA_W-1:0] v);
    return en ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring radix-2 division iteration.
// The 64-bit partial remainder holds {remainder, dividend/quotient}; each step
// shifts left by one, trial-subtracts the divisor from the upper half and, if
// it fits, keeps the difference and shifts a 1 quotient bit into bit 0.
// Ports:
//   i_rem     [63:0] partial remainder before the step
//   i_divisor [31:0] divisor magnitude
//   o_rem     [63:0] partial remainder after the step (quotient bit in bit 0)
// -----------------------------------------------------------------------------
module div_step
  import div_unit_pkg::*;
(
  input  logic [RESULT_W-1:0] i_rem,
  input  logic [DATA_W-1:0]   i_divisor,
  output logic [RESULT_W-1:0] o_rem
);

  logic [RESULT_W:0] w_shift;
  logic [DATA_W+1:0] w_diff;
  logic              w_q_bit;

  always_comb begin
    w_shift = {i_rem, 1'b0};
    // The shifted upper half can reach 33 bits; one extra bit holds the borrow.
    w_diff  = {1'b0, w_shift[RESULT_W:DATA_W]} - {2'b00, i_divisor};
    w_q_bit = ~w_diff[DATA_W+1];
    o_rem   = w_q_bit ? {w_diff[DATA_W-1:0], w_shift[DATA_W-1:1], 1'b1}
                      : w_shift[RESULT_W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle 32-bit DIV/DIVU unit feeding the HI/LO register file.
// start accepted in IDLE (cycle 0), 32 restoring steps in CALC (cycles 1..32),
// result presented with done/hi_we/lo_we in FINISH (cycle 33).
// annul aborts CALC/FINISH and suppresses the write pulse; annul beats start.
// Configuration macro: DIV_FAST_ZERO_EN -- a zero divisor takes the ZERO
// shortcut and finishes in cycle 2 with hi_in=dividend, lo_in=0xFFFFFFFF.
// Ports:
//   clk, rst (async, active-low)
//   start, signed_op, opdata1 (dividend), opdata2 (divisor), annul
//   busy, stall_req, done, hi_we, lo_we
//   hi_in (remainder), lo_in (quotient)
// -----------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] opdata1,
  input  logic [DATA_W-1:0] opdata2,
  input  logic              annul,
  output logic              busy,
  output logic              stall_req,
  output logic              done,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DATA_W-1:0] hi_in,
  output logic [DATA_W-1:0] lo_in
);

  div_state_t          r_state;
  div_state_t          w_next;
  logic [RESULT_W-1:0] r_rem;
  logic [DATA_W-1:0]   r_divisor;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_signed;
  logic                r_sign_a;
  logic                r_sign_b;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  logic                w_start_ok;
  logic [RESULT_W-1:0] w_step_rem;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_remd;

  assign w_start_ok = (r_state == IDLE) & start & ~annul;

  div_step u_div_step (
    .i_rem     (r_rem),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem)
  );

  // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
  assign w_quot = neg_if(r_signed & (r_sign_a ^ r_sign_b), r_rem[DATA_W-1:0]);
  assign w_remd = neg_if(r_signed & r_sign_a, r_rem[RESULT_W-1:DATA_W]);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    busy      = (r_state != IDLE);
    done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start_ok) begin
`ifdef DIV_FAST_ZERO_EN
          w_next = (opdata2 == '0) ? ZERO : CALC;
`else
          w_next = CALC;
`endif
        end
      end
      CALC: begin
        if (annul)                                w_next = IDLE;
        else if (r_cnt == CNT_W'(DIV_STEPS - 1))  w_next = FINISH;
      end
`ifdef DIV_FAST_ZERO_EN
      ZERO: begin
        w_next = annul ? IDLE : FINISH;
      end
`endif
      FINISH: begin
        w_next = IDLE;
        done   = ~annul;
      end
      default: w_next = IDLE;
    endcase
    hi_we     = done;
    lo_we     = done;
    stall_req = busy & ~done;
    hi_in     = done ? w_remd : r_hi;
    lo_in     = done ? w_quot : r_lo;
  end

  // NOTE: these are plain registers, not a memory array, so all of them are
  // cleared by reset; an aborted operation leaves nothing behind to complete.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      if (w_start_ok) begin
        r_signed  <= signed_op;
        r_sign_a  <= signed_op & opdata1[DATA_W-1];
        r_sign_b  <= signed_op & opdata2[DATA_W-1];
        r_divisor <= neg_if(signed_op & opdata2[DATA_W-1], opdata2);
        r_rem     <= {{DATA_W{1'b0}}, neg_if(signed_op & opdata1[DATA_W-1], opdata1)};
        r_cnt     <= '0;
`ifdef DIV_FAST_ZERO_EN
        if (opdata2 == '0) begin
          // Preload the fixed zero-divisor result; no sign fix-up applies.
          r_signed <= 1'b0;
          r_rem    <= {opdata1, {DATA_W{1'b1}}};
        end
`endif
      end else if (r_state == CALC) begin
        r_rem <= w_step_rem;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (done) begin
        r_hi <= w_remd;
        r_lo <= w_quot;
      end
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: request a division using the operands present in the same cycle.
REQ-004 SHALL have port signed_op, input, 1 bit: 1 selects DIV (signed), 0 selects DIVU (unsigned).
REQ-005 SHALL have port opdata1, input, 32 bits: dividend.
REQ-006 SHALL have port opdata2, input, 32 bits: divisor.
REQ-007 SHALL have port annul, input, 1 bit: flush request; aborts any operation in progress.
REQ-008 SHALL have port busy, output, 1 bit: an operation is in progress, including the completion cycle.
REQ-009 SHALL have port stall_req, output, 1 bit: pipeline stall request, equal to busy & ~done.
REQ-010 SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-011 SHALL have ports hi_we and lo_we, output, 1 bit each: HI/LO write enables, both equal to done.
REQ-012 SHALL have port hi_in, output, 32 bits: remainder, which feeds the HI/LO register file.
REQ-013 SHALL have port lo_in, output, 32 bits: quotient, which feeds the HI/LO register file.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC and FINISH (plus ZERO when DIV_FAST_ZERO_EN is defined).
REQ-015 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-016 SHALL, when start is accepted in cycle 0, latch the magnitudes of opdata1 and opdata2 (absolute values when signed_op=1), the operation kind, and both operand signs.
REQ-017 SHALL perform one restoring radix-2 step per cycle in CALC during cycles 1..32, using a 64-bit partial-remainder register and a 6-bit step counter.
REQ-018 SHALL enter FINISH in cycle 33 and assert done, hi_we and lo_we for exactly that cycle, then return to IDLE.
REQ-019 SHALL hold busy at 1 from cycle 1 through cycle 33.
REQ-020 SHALL, for signed operations, negate the quotient when the operand signs differ and give the remainder the sign of the dividend.
REQ-021 SHALL compute 0x80000000 / 0xFFFFFFFF (signed) as lo_in=0x80000000 and hi_in=0 (two's-complement wrap, no trap).
REQ-022 SHALL, when annul is asserted in CALC or FINISH, return to IDLE at the next edge with done, hi_we and lo_we held at 0 in that same cycle.
REQ-023 SHALL give annul priority over start when both are asserted in IDLE, so no operation starts.
REQ-024 SHALL hold hi_in and lo_in at their last completed result outside FINISH.

Reset
REQ-025 SHALL, while rst=0, force the state to IDLE and drive busy, done, hi_we, lo_we, hi_in, lo_in and the internal registers to 0.
REQ-026 SHALL, when reset asserts mid-operation, discard the operation with no write pulse after reset releases.

Configuration
REQ-027 SHALL, when DIV_FAST_ZERO_EN is defined and opdata2=0 at start, go to ZERO in cycle 1 and then FINISH in cycle 2, with hi_in=opdata1 and lo_in=0xFFFFFFFF.
REQ-028 SHALL, when DIV_FAST_ZERO_EN is undefined, run a zero divisor through the normal 33-cycle path, with a result that is architecturally unpredictable but still delivered with the done pulse.

Structure
REQ-029 SHALL place the FSM state encoding, DIV_STEPS=32 and the 64-bit result width in the shared defines package.
REQ-030 SHALL contain one sub-module, div_step: a combinational single restoring iteration (64-bit remainder in, 64-bit remainder out, carrying the quotient bit).

Verification
REQ-031 SHALL cover: DIVU 100/7 -> done in cycle 33, lo_in=14, hi_in=2, hi_we=lo_we=1 for one cycle.
REQ-032 SHALL cover: DIV -7/2 -> lo_in=0xFFFFFFFD, hi_in=0xFFFFFFFF; DIV 0x80000000/-1 -> lo_in=0x80000000, hi_in=0.
REQ-033 SHALL cover: annul asserted in cycle 10 -> busy=0 from cycle 11, no done pulse, a following start accepted normally.
REQ-034 SHALL cover: a second start asserted in cycles 5..20 -> ignored, exactly one done pulse, in cycle 33.
REQ-035 SHALL cover: 5/0 with DIV_FAST_ZERO_EN defined -> done in cycle 2, hi_in=5, lo_in=0xFFFFFFFF; with it undefined -> done in cycle 33.
REQ-036 SHALL cover: rst=0 pulsed in cycle 15 -> all outputs 0 immediately, no done pulse afterwards.
